// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int REGISTER_FILE_ADDRESS_LEN = 4;
  localparam int WAIT_W                    = 16;

  typedef enum logic {
    PCTRL_RUN      = 1'b0,
    PCTRL_MEM_WAIT = 1'b1
  } pctrl_state_e;

  typedef struct packed {
    logic hazard;
    logic freeze_if;
    logic freeze_id;
    logic flush_if;
    logic flush_id;
    logic freeze_back;
  } pctrl_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect_unit.sv
// Combinational RAW detector between the ID sources and the EX/MEM destinations.
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN
) (
  input  logic              forward_en,
  input  logic [ADDR_W-1:0] id_src_1,
  input  logic [ADDR_W-1:0] id_src_2,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              mem_wb_en,
  output logic              raw
);

  logic ex_hit, mem_hit;

  assign ex_hit  = ex_wb_en  & ((ex_dest  == id_src_1) | (id_two_src & (ex_dest  == id_src_2)));
  assign mem_hit = mem_wb_en & ((mem_dest == id_src_1) | (id_two_src & (mem_dest == id_src_2)));

  // With forwarding only a load in EX cannot be bypassed in time.
  assign raw = forward_en ? (ex_hit & ex_mem_r_en) : (ex_hit | mem_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: memory freeze > branch flush > data hazard, plus perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W      = REGISTER_FILE_ADDRESS_LEN,
  parameter int PERF_W      = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic [ADDR_W-1:0] id_src_1,
  input  logic [ADDR_W-1:0] id_src_2,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              branch_taken,
  input  logic              mem_stage_req,
  input  logic              mem_ready,
  output logic              hazard,
  output logic              freeze_if,
  output logic              freeze_id,
  output logic              flush_if,
  output logic              flush_id,
  output logic              freeze_back,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] memwait_cnt,
  output logic              mem_timeout
);

  localparam logic [PERF_W-1:0] P_ONE = PERF_W'(1);
  localparam logic [WAIT_W-1:0] W_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] TMO   = WAIT_W'(MEM_TIMEOUT);

  pctrl_state_e      state_q, state_d;
  pctrl_ctrl_t       ctrl;
  logic              raw, mem_hold;
  logic [PERF_W-1:0] stall_q, stall_d, flush_q, flush_d, mwait_q, mwait_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              tmo_q, tmo_d;

  hazard_detect_unit #(.ADDR_W(ADDR_W)) u_hdu (
    .forward_en  (forward_en),
    .id_src_1    (id_src_1),
    .id_src_2    (id_src_2),
    .id_two_src  (id_two_src),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_r_en (ex_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .raw         (raw)
  );

  assign mem_hold = ((state_q == PCTRL_RUN) & mem_stage_req & ~mem_ready) |
                    ((state_q == PCTRL_MEM_WAIT) & ~mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PCTRL_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mem_hold) state_d = PCTRL_MEM_WAIT;
    else          state_d = PCTRL_RUN;
  end

  // Controls are forced low while reset is held so no register moves.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      if (mem_hold) begin
        ctrl.freeze_if   = 1'b1;
        ctrl.freeze_id   = 1'b1;
        ctrl.freeze_back = 1'b1;
      end else if (branch_taken) begin
        ctrl.flush_if = 1'b1;
        ctrl.flush_id = 1'b1;
      end else if (raw) begin
        ctrl.hazard    = 1'b1;
        ctrl.freeze_if = 1'b1;
      end
    end
  end

  assign hazard      = ctrl.hazard;
  assign freeze_if   = ctrl.freeze_if;
  assign freeze_id   = ctrl.freeze_id;
  assign flush_if    = ctrl.flush_if;
  assign flush_id    = ctrl.flush_id;
  assign freeze_back = ctrl.freeze_back;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    mwait_d = mwait_q;
    if (ctrl.hazard      && !(&stall_q)) stall_d = stall_q + P_ONE;
    if (ctrl.flush_id    && !(&flush_q)) flush_d = flush_q + P_ONE;
    if (ctrl.freeze_back && !(&mwait_q)) mwait_d = mwait_q + P_ONE;
  end

  // Wait counter is zero on the first MEM_WAIT cycle and counts MEM_WAIT cycles.
  assign wait_inc = (&wait_q) ? wait_q : wait_q + W_ONE;

  always_comb begin
    wait_d = '0;
    tmo_d  = tmo_q;
    if (state_q == PCTRL_MEM_WAIT) begin
      wait_d = wait_inc;
      if (wait_inc >= TMO) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
      mwait_q <= '0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      mwait_q <= mwait_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign memwait_cnt = mwait_q;
  assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: a default instance and a small one (PERF_W=2, MEM_TIMEOUT=4) share stimulus.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic forward_en, id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic branch_taken, mem_stage_req, mem_ready;
  logic [3:0] id_src_1, id_src_2, ex_dest, mem_dest;

  logic hz_a, fif_a, fid_a, flif_a, flid_a, fb_a, tmo_a;
  logic hz_b, fif_b, fid_b, flif_b, flid_b, fb_b, tmo_b;
  logic [15:0] st_a, fl_a, mw_a;
  logic [1:0]  st_b, fl_b, mw_b;

  int n_chk = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];
  int m_st_a, m_fl_a, m_mw_a, m_st_b, m_fl_b, m_mw_b;
  logic m_tmo_b;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] HZ   = 6'b110000;
  localparam logic [5:0] BR   = 6'b000110;
  localparam logic [5:0] MEMF = 6'b011001;

  always #5 clk = ~clk;

  pipeline_ctrl dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_stage_req(mem_stage_req), .mem_ready(mem_ready),
    .hazard(hz_a), .freeze_if(fif_a), .freeze_id(fid_a), .flush_if(flif_a), .flush_id(flid_a),
    .freeze_back(fb_a), .stall_cnt(st_a), .flush_cnt(fl_a), .memwait_cnt(mw_a), .mem_timeout(tmo_a)
  );

  pipeline_ctrl #(.ADDR_W(4), .PERF_W(2), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_stage_req(mem_stage_req), .mem_ready(mem_ready),
    .hazard(hz_b), .freeze_if(fif_b), .freeze_id(fid_b), .flush_if(flif_b), .flush_id(flid_b),
    .freeze_back(fb_b), .stall_cnt(st_b), .flush_cnt(fl_b), .memwait_cnt(mw_b), .mem_timeout(tmo_b)
  );

  wire [5:0] ctrl_a = {hz_a, fif_a, fid_a, flif_a, flid_a, fb_a};
  wire [5:0] ctrl_b = {hz_b, fif_b, fid_b, flif_b, flid_b, fb_b};

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic idle();
    forward_en = 1'b1; id_two_src = 1'b0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_stage_req = 1'b0; mem_ready = 1'b0;
    id_src_1 = 4'd0; id_src_2 = 4'd0; ex_dest = 4'd0; mem_dest = 4'd0;
  endtask

  // Inputs are already driven; push the expected controls, compare mid-cycle, then counters after the edge.
  task automatic cyc(string tag, logic [5:0] e);
    logic [5:0] ev;
    exp_q.push_back(e);
    @(negedge clk);
    ev = exp_q.pop_front();
    chk({tag, "_ctrl_a"}, {26'd0, ctrl_a}, {26'd0, ev});
    chk({tag, "_ctrl_b"}, {26'd0, ctrl_b}, {26'd0, ev});
    if (ev[5]) begin m_st_a = sat(m_st_a, 65535); m_st_b = sat(m_st_b, 3); end
    if (ev[1]) begin m_fl_a = sat(m_fl_a, 65535); m_fl_b = sat(m_fl_b, 3); end
    if (ev[0]) begin m_mw_a = sat(m_mw_a, 65535); m_mw_b = sat(m_mw_b, 3); end
    @(posedge clk); #1;
    chk({tag, "_stall_a"}, {16'd0, st_a}, m_st_a);
    chk({tag, "_flush_a"}, {16'd0, fl_a}, m_fl_a);
    chk({tag, "_mwait_a"}, {16'd0, mw_a}, m_mw_a);
    chk({tag, "_stall_b"}, {30'd0, st_b}, m_st_b);
    chk({tag, "_flush_b"}, {30'd0, fl_b}, m_fl_b);
    chk({tag, "_mwait_b"}, {30'd0, mw_b}, m_mw_b);
    chk({tag, "_tmo_a"}, {31'd0, tmo_a}, 32'd0);
    chk({tag, "_tmo_b"}, {31'd0, tmo_b}, {31'd0, m_tmo_b});
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ctrl_a"}, {26'd0, ctrl_a}, 32'd0);
    chk({tag, "_ctrl_b"}, {26'd0, ctrl_b}, 32'd0);
    chk({tag, "_cnt_a"}, {st_a, fl_a}, 32'd0);
    chk({tag, "_cnt_b"}, {26'd0, st_b, fl_b, mw_b}, 32'd0);
    chk({tag, "_mw_tmo_a"}, {15'd0, mw_a, tmo_a}, 32'd0);
    chk({tag, "_tmo_b"}, {31'd0, tmo_b}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_st_a = 0; m_fl_a = 0; m_mw_a = 0; m_st_b = 0; m_fl_b = 0; m_mw_b = 0; m_tmo_b = 1'b0;
    // Reset held with a freeze-worthy input pattern: controls must stay low.
    idle();
    mem_stage_req = 1'b1; branch_taken = 1'b1;
    #3 chk_reset("reset");
    @(posedge clk); #1 rst = 1'b1;
    idle();
    cyc("idle", NONE);

    // Load-use with forwarding: one stall, then the load is in MEM and is forwarded.
    ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 4'd3; id_src_1 = 4'd3;
    cyc("loaduse", HZ);
    ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3;
    cyc("loaduse_clear", NONE);

    // No forwarding: MEM destination against the second source.
    idle();
    forward_en = 1'b0; mem_dest = 4'd5; mem_wb_en = 1'b1; id_src_2 = 4'd5; id_two_src = 1'b1;
    cyc("nofwd_src2", HZ);
    id_two_src = 1'b0;
    cyc("nofwd_one_src", NONE);

    // Branch outranks a live hazard.
    id_two_src = 1'b1; branch_taken = 1'b1;
    cyc("branch_vs_raw", BR);
    idle();
    cyc("after_branch", NONE);

    // Memory wait of three cycles, then release and confirm FSM is back in RUN.
    mem_stage_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("memwait", MEMF);
    mem_ready = 1'b1;
    cyc("mem_release", NONE);
    idle();
    cyc("mem_run", NONE);

    // Branch held through a freeze flushes on the release cycle.
    mem_stage_req = 1'b1; branch_taken = 1'b1;
    cyc("br_frozen", MEMF);
    mem_ready = 1'b1;
    cyc("br_release", BR);
    idle();

    // Timeout: six low cycles; the small instance flags after its 4th MEM_WAIT cycle.
    mem_stage_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      m_tmo_b = (k >= 5);
      cyc("timeout_wait", MEMF);
    end
    mem_ready = 1'b1;
    cyc("timeout_release", NONE);
    idle();
    cyc("timeout_sticky", NONE);

    // Five stalls saturate the 2-bit counter.
    forward_en = 1'b0; ex_wb_en = 1'b1; ex_dest = 4'd7; id_src_1 = 4'd7;
    for (int i = 0; i < 5; i++) cyc("sat_stall", HZ);
    chk("sat_stall_b_final", {30'd0, st_b}, 32'd3);
    idle();

    // Reset in the middle of a memory wait.
    mem_stage_req = 1'b1;
    cyc("pre_rst_wait", MEMF);
    #2 rst = 1'b0;
    #1 chk_reset("rst_midwait");
    m_st_a = 0; m_fl_a = 0; m_mw_a = 0; m_st_b = 0; m_fl_b = 0; m_mw_b = 0; m_tmo_b = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    mem_stage_req = 1'b0;
    cyc("post_rst_run", NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
